// File: rtl/fa16_share_arbiter.sv
// Round-robin arbiter sharing one external 16-bit ripple adder (FA16b) between NREQ requesters.
// Optional carry-chained, locked multi-word adds are built when FA_ARB_CHAIN_EN is defined.
module fa16_share_arbiter #(
  parameter int NREQ = 3,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  input  logic [NREQ-1:0]   op_cin,
`ifdef FA_ARB_CHAIN_EN
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ-1:0]   req_chain,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy,
  output logic [W-1:0]      fa_a,
  output logic [W-1:0]      fa_b,
  output logic              fa_cin,
  input  logic [W-1:0]      fa_sum,
  input  logic              fa_cout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            cin_sel;

`ifdef FA_ARB_CHAIN_EN
  logic            lock_q;
  logic [IW-1:0]   lock_id_q;
  logic            carry_q;
`endif

  assign busy = (state_q == EXEC);

  // Winner search starts one past the last grant so every held request is reached within NREQ grants.
  always_comb begin
    elig      = req;
    win_found = 1'b0;
    win       = ptr_q;
    idx       = '0;
`ifdef FA_ARB_CHAIN_EN
    if (lock_q)
      elig = req & (NREQ'(1) << lock_id_q);
`endif
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    cin_sel = op_cin[win];
`ifdef FA_ARB_CHAIN_EN
    if (req_chain[win])
      cin_sel = carry_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: grant edge latches operands into the adder; exec edge captures the settled result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NREQ - 1);
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      fa_a      <= '0;
      fa_b      <= '0;
      fa_cin    <= 1'b0;
`ifdef FA_ARB_CHAIN_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      carry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt       <= '0;
      rsp_valid <= '0;
      if (state_q == IDLE && win_found) begin
        gnt    <= NREQ'(1) << win;
        ptr_q  <= win;
        fa_a   <= op_a[int'(win)*W +: W];
        fa_b   <= op_b[int'(win)*W +: W];
        fa_cin <= cin_sel;
`ifdef FA_ARB_CHAIN_EN
        // Only the lock holder can win while locked, so this both sets and releases the lock.
        lock_q <= req_lock[win];
        if (req_lock[win])
          lock_id_q <= win;
`endif
      end
      if (state_q == EXEC) begin
        rsp_sum   <= fa_sum;
        rsp_cout  <= fa_cout;
        rsp_valid <= NREQ'(1) << ptr_q;
`ifdef FA_ARB_CHAIN_EN
        carry_q   <= fa_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fa16_share_arbiter.sv
// Scoreboard bench for fa16_share_arbiter: models FA16b combinationally, queues expected grants/results.
// Chain/lock scenario is exercised when FA_ARB_CHAIN_EN is defined.
module tb_fa16_share_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] op_a = '0;
  logic [NREQ*W-1:0] op_b = '0;
  logic [NREQ-1:0]   op_cin = '0;
`ifdef FA_ARB_CHAIN_EN
  logic [NREQ-1:0]   req_lock = '0;
  logic [NREQ-1:0]   req_chain = '0;
`endif
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [W-1:0]      rsp_sum, fa_a, fa_b, fa_sum;
  logic              rsp_cout, busy, fa_cin, fa_cout;

  fa16_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
`ifdef FA_ARB_CHAIN_EN
    .req_lock(req_lock), .req_chain(req_chain),
`endif
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  always #5 clk = ~clk;

  // External FA16b
  assign {fa_cout, fa_sum} = {1'b0, fa_a} + {1'b0, fa_b} + {16'd0, fa_cin};

  int n_chk = 0;
  int n_fail = 0;
  int gq[$];
  int rq_id[$];
  logic [16:0] rq_val[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b, input logic c);
    op_a[id*W +: W] = a;
    op_b[id*W +: W] = b;
    op_cin[id]      = c;
  endtask

  task automatic push_exp(input int id, input logic [16:0] v);
    gq.push_back(id);
    rq_id.push_back(id);
    rq_val.push_back(v);
  endtask

  function automatic logic [16:0] add_ref(input logic [15:0] a, input logic [15:0] b, input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  task automatic wait_gnt(input int id, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[id] && n < budget);
    if (!gnt[id]) chk("gnt_timeout", 32'(id), 32'hFFFF_FFFF);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((gq.size() != 0 || rq_id.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(gq.size() + rq_id.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    set_ops(id, a, b, c);
    push_exp(id, add_ref(a, b, c));
    req[id] = 1'b1;
    wait_gnt(id, 20, n);
    chk("gnt_lat", 32'(n), 1);
    req[id] = 1'b0;
    @(negedge clk);
    chk("rsp_lat", 32'(rsp_valid), 32'(1 << id));
    @(negedge clk);
  endtask

  // Monitor: every grant and response is matched against the queue heads
  logic [NREQ-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    int id;
    logic [16:0] v;
    if (gnt != '0) begin
      chk("gnt_b2b", 32'(prev_gnt), 0);
      chk("busy_exec", 32'(busy), 1);
      if (gq.size() == 0) chk("gnt_unexp", 32'(gnt), 0);
      else begin
        id = gq.pop_front();
        chk("gnt_id", 32'(gnt), 32'(1 << id));
      end
    end
    if (rsp_valid != '0) begin
      if (rq_id.size() == 0) chk("rsp_unexp", 32'(rsp_valid), 0);
      else begin
        id = rq_id.pop_front();
        v  = rq_val.pop_front();
        chk("rsp_id", 32'(rsp_valid), 32'(1 << id));
        chk("rsp_sum", 32'(rsp_sum), 32'(v[15:0]));
        chk("rsp_cout", 32'(rsp_cout), 32'(v[16]));
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    logic seen;

    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_sum", 32'(rsp_sum), 0);
    chk("rst_rsp_cout", 32'(rsp_cout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fa_a", 32'(fa_a), 0);
    chk("rst_fa_b", 32'(fa_b), 0);
    chk("rst_fa_cin", 32'(fa_cin), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single ops and wrap-around; last op by requester 2 leaves the pointer at 2
    do_op(0, 16'h1234, 16'h0001, 1'b0);
    do_op(1, 16'hFFFF, 16'h0001, 1'b0);
    do_op(2, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("fa_hold_a", 32'(fa_a), 32'h0000_FFFF);
    chk("fa_hold_cin", 32'(fa_cin), 1);
    drain(10);

    // Contention: all three held, expect 0,1,2,0
    set_ops(0, 16'h1000, 16'h0111, 1'b0);
    set_ops(1, 16'h2222, 16'h0333, 1'b1);
    set_ops(2, 16'h8000, 16'h8000, 1'b0);
    push_exp(0, add_ref(16'h1000, 16'h0111, 1'b0));
    push_exp(1, add_ref(16'h2222, 16'h0333, 1'b1));
    push_exp(2, add_ref(16'h8000, 16'h8000, 1'b0));
    push_exp(0, add_ref(16'h1000, 16'h0111, 1'b0));
    req = 3'b111;
    cnt = 0;
    n = 0;
    while (cnt < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (gnt != '0) cnt++;
    end
    chk("contend_cnt", 32'(cnt), 4);
    req = '0;
    drain(10);

    // Reset during EXEC: op 1 is discarded, pointer returns to favour requester 0
    set_ops(1, 16'h4444, 16'h1111, 1'b0);
    gq.push_back(1);
    req[1] = 1'b1;
    wait_gnt(1, 20, n);
    req[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstx_rsp_valid", 32'(rsp_valid), 0);
    chk("rstx_gnt", 32'(gnt), 0);
    chk("rstx_busy", 32'(busy), 0);
    chk("rstx_rsp_sum", 32'(rsp_sum), 0);
    chk("rstx_fa_a", 32'(fa_a), 0);
    rst = 1'b0;
    push_exp(0, add_ref(16'h1000, 16'h0111, 1'b0));
    req = 3'b111;
    wait_gnt(0, 20, n);
    chk("rstx_first_gnt", 32'(gnt), 32'b001);
    req = '0;
    drain(10);

    // Dropped request: req[2] pulsed while requester 0 is being served
    set_ops(0, 16'h0F0F, 16'h00F1, 1'b1);
    push_exp(0, add_ref(16'h0F0F, 16'h00F1, 1'b1));
    req[0] = 1'b1;
    wait_gnt(0, 20, n);
    req[0] = 1'b0;
    req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (gnt[2]) seen = 1'b1;
    end
    chk("drop_gnt2", 32'(seen), 0);
    drain(10);

`ifdef FA_ARB_CHAIN_EN
    // Locked two-word add by requester 1 while requester 0 waits
    do_op(0, 16'h0001, 16'h0001, 1'b0);
    drain(10);
    set_ops(1, 16'hFFFF, 16'h0001, 1'b0);
    set_ops(0, 16'h0100, 16'h0001, 1'b0);
    push_exp(1, 17'h1_0000);
    push_exp(1, 17'h0_0001);
    push_exp(0, 17'h0_0101);
    req_lock[1] = 1'b1;
    req = 3'b011;
    wait_gnt(1, 20, n);
    set_ops(1, 16'h0000, 16'h0000, 1'b0);
    req_lock[1]  = 1'b0;
    req_chain[1] = 1'b1;
    wait_gnt(1, 20, n);
    chk("chain_b2b_wait", 32'(n), 2);
    req[1] = 1'b0;
    req_chain[1] = 1'b0;
    wait_gnt(0, 20, n);
    req[0] = 1'b0;
    drain(10);
`endif

    drain(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
